// File: rtl/rob_pkg.sv
// Shared types for the pack-granular ROB completion tracker.
// A pack holds two instruction slots; a ROB id is {pack index, slot}.
package rob_pkg;

    localparam int PACKS = 16;

    typedef logic [3:0] pack_id_t;
    typedef logic [4:0] rob_id_t;
    typedef logic [4:0] rob_ptr_t;
    typedef logic [4:0] excp_code_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] done;
        logic       excp;
        logic       excp_slot;
        excp_code_t excp_code;
    } rob_pack_t;

    // Slots that retire: everything allocated, or only slots older than the excepting one.
    function automatic logic [1:0] retire_mask(logic [1:0] alloc, logic excp, logic excp_slot);
        if (!excp) begin
            return alloc;
        end
        return excp_slot ? (alloc & 2'b01) : 2'b00;
    endfunction

endpackage

// File: rtl/rob_wrap_ptr.sv
// Wrap-bit pointer register (4-bit index + wrap bit) used for ROB head and tail.
// Synchronous clear takes priority over increment; asynchronous reset to zero.
module rob_wrap_ptr
    import rob_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [4:0] ptr_o
);

    rob_ptr_t ptr_q;
    rob_ptr_t ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_completion_tracker.sv
// Pack-granular completion tracker: allocates 2-slot packs, collects completions and
// exceptions, and offers the oldest complete pack to commit. ROB_PERF_CNT_EN adds perf counters.
module rob_completion_tracker
    import rob_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_i,
    input  logic             flush_i,
    input  logic             alloc_vld_i,
    input  logic [1:0]       alloc_slot_vld_i,
    output logic [3:0]       alloc_pack_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [4:0]       occupancy_o,
    input  logic             alu0_complete,
    input  logic [4:0]       alu0_rob_id,
    input  logic             alu1_complete,
    input  logic [4:0]       alu1_rob_id,
    input  logic             mem_complete_i,
    input  logic [4:0]       mem_rob_id_i,
    input  logic             excp_valid,
    input  logic [5:0]       excp_rob,
    input  logic [4:0]       excp_code,
    output logic             commit_vld_o,
    input  logic             commit_rdy_i,
    output logic [3:0]       commit_pack_o,
    output logic [1:0]       commit_mask_o,
    output logic             commit_excp_o,
    output logic [4:0]       commit_excp_code_o,
    output logic             commit_excp_slot_o,
    output logic [CNT_W-1:0] perf_commit_cnt_o,
    output logic [CNT_W-1:0] perf_stall_cnt_o
);

    rob_pack_t [PACKS-1:0]      pack_q, pack_d;
    logic [PACKS-1:0][1:0]      amask_q, amask_d;
    rob_ptr_t                   head_ptr, tail_ptr;
    pack_id_t                   head_idx, tail_idx, excp_idx;
    logic [4:0]                 occupancy;
    logic                       full, empty, commit_vld, do_commit, do_alloc;
    logic [2:0]                 cpl_vld;
    rob_id_t                    cpl_id [3];
    logic                       unused_excp_hi;

    assign unused_excp_hi = excp_rob[5];

    assign head_idx   = head_ptr[3:0];
    assign tail_idx   = tail_ptr[3:0];
    assign excp_idx   = excp_rob[4:1];
    assign occupancy  = tail_ptr - head_ptr;
    assign full       = (occupancy == 5'(PACKS));
    assign empty      = (occupancy == 5'd0);
    assign commit_vld = !empty && (pack_q[head_idx].done == 2'b11);
    // Full is judged on registered state, so a same-cycle retire does not free a slot early.
    assign do_commit  = commit_vld & commit_rdy_i & !flush_i;
    assign do_alloc   = alloc_vld_i & !full & !flush_i;

    assign cpl_vld = {mem_complete_i, alu1_complete, alu0_complete};
    assign cpl_id[0] = alu0_rob_id;
    assign cpl_id[1] = alu1_rob_id;
    assign cpl_id[2] = mem_rob_id_i;

    rob_wrap_ptr u_head (
        .clk_i (cpu_clock_i),
        .rst_i (cpu_reset_i),
        .clr_i (flush_i),
        .inc_i (do_commit),
        .ptr_o (head_ptr)
    );

    rob_wrap_ptr u_tail (
        .clk_i (cpu_clock_i),
        .rst_i (cpu_reset_i),
        .clr_i (flush_i),
        .inc_i (do_alloc),
        .ptr_o (tail_ptr)
    );

    always_comb begin
        pack_d  = pack_q;
        amask_d = amask_q;
        for (int p = 0; p < 3; p++) begin
            if (cpl_vld[p] && pack_q[cpl_id[p][4:1]].valid) begin
                pack_d[cpl_id[p][4:1]].done[cpl_id[p][0]] = 1'b1;
            end
        end
        if (excp_valid && pack_q[excp_idx].valid) begin
            pack_d[excp_idx].done[excp_rob[0]] = 1'b1;
            // Earliest slot wins when a pack reports more than one exception.
            if (!pack_q[excp_idx].excp || (excp_rob[0] < pack_q[excp_idx].excp_slot)) begin
                pack_d[excp_idx].excp      = 1'b1;
                pack_d[excp_idx].excp_slot = excp_rob[0];
                pack_d[excp_idx].excp_code = excp_code;
            end
        end
        if (do_commit) begin
            pack_d[head_idx].valid = 1'b0;
        end
        if (do_alloc) begin
            pack_d[tail_idx] = '{valid: 1'b1, done: ~alloc_slot_vld_i, excp: 1'b0,
                                 excp_slot: 1'b0, excp_code: '0};
            amask_d[tail_idx] = alloc_slot_vld_i;
        end
        if (flush_i) begin
            for (int i = 0; i < PACKS; i++) begin
                pack_d[i].valid = 1'b0;
                pack_d[i].excp  = 1'b0;
            end
        end
    end

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            pack_q  <= '0;
            amask_q <= '0;
        end else begin
            pack_q  <= pack_d;
            amask_q <= amask_d;
        end
    end

    assign alloc_pack_o       = tail_idx;
    assign full_o             = full;
    assign empty_o            = empty;
    assign occupancy_o        = occupancy;
    assign commit_vld_o       = commit_vld;
    assign commit_pack_o      = head_idx;
    assign commit_mask_o      = commit_vld ? retire_mask(amask_q[head_idx], pack_q[head_idx].excp,
                                                         pack_q[head_idx].excp_slot) : 2'b00;
    assign commit_excp_o      = commit_vld & pack_q[head_idx].excp;
    assign commit_excp_code_o = commit_excp_o ? pack_q[head_idx].excp_code : '0;
    assign commit_excp_slot_o = commit_excp_o & pack_q[head_idx].excp_slot;

`ifdef ROB_PERF_CNT_EN
    logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        commit_cnt_d = commit_cnt_q;
        if (do_commit) begin
            commit_cnt_d = commit_cnt_q + CNT_W'(commit_mask_o[0]) + CNT_W'(commit_mask_o[1]);
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(!empty & !commit_vld);
    end

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            commit_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign perf_commit_cnt_o = commit_cnt_q;
    assign perf_stall_cnt_o  = stall_cnt_q;
`else
    assign perf_commit_cnt_o = '0;
    assign perf_stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_rob_completion_tracker.sv
// Bench for rob_completion_tracker: directed scenarios plus random traffic, checked per cycle
// against a queue-of-packs reference model through an expectation scoreboard.
module tb_rob_completion_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, alloc_vld, commit_rdy;
    logic [1:0]  alloc_slot;
    logic        alu0, alu1, mem, excp_v;
    logic [4:0]  alu0_id, alu1_id, mem_id, excp_cd;
    logic [5:0]  excp_id;
    logic [3:0]  alloc_pack, commit_pack;
    logic        full, empty, commit_vld, commit_excp, commit_excp_slot;
    logic [4:0]  occupancy, commit_excp_code;
    logic [1:0]  commit_mask;
    logic [31:0] perf_commit, perf_stall;

    always #5 clk = ~clk;

    rob_completion_tracker #(.CNT_W(32)) dut (
        .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush),
        .alloc_vld_i(alloc_vld), .alloc_slot_vld_i(alloc_slot), .alloc_pack_o(alloc_pack),
        .full_o(full), .empty_o(empty), .occupancy_o(occupancy),
        .alu0_complete(alu0), .alu0_rob_id(alu0_id), .alu1_complete(alu1), .alu1_rob_id(alu1_id),
        .mem_complete_i(mem), .mem_rob_id_i(mem_id),
        .excp_valid(excp_v), .excp_rob(excp_id), .excp_code(excp_cd),
        .commit_vld_o(commit_vld), .commit_rdy_i(commit_rdy), .commit_pack_o(commit_pack),
        .commit_mask_o(commit_mask), .commit_excp_o(commit_excp),
        .commit_excp_code_o(commit_excp_code), .commit_excp_slot_o(commit_excp_slot),
        .perf_commit_cnt_o(perf_commit), .perf_stall_cnt_o(perf_stall)
    );

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] am;
        logic [1:0] done;
        logic       ex;
        logic       es;
        logic [4:0] ec;
    } mp_t;

    typedef struct packed {
        logic        vld;
        logic [3:0]  pk;
        logic [1:0]  mask;
        logic        ex;
        logic        es;
        logic [4:0]  ec;
        logic        full;
        logic        empty;
        logic [4:0]  occ;
        logic [3:0]  ap;
        logic [31:0] pc;
        logic [31:0] ps;
    } exp_t;

    mp_t         mq[$];
    exp_t        exp_q[$];
    int          m_tail;
    logic [31:0] m_pc, m_ps;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_mask(mp_t p);
        logic [1:0] m;
        if (!p.ex) return p.am;
        m = 2'b00;
        for (int s = 0; s < 2; s++) begin
            if (s < int'(p.es)) m[s] = p.am[s];
        end
        return m;
    endfunction

    // Offset of a pack from the oldest held pack, or -1 when the pack is not held.
    function automatic int held_off(logic [3:0] pk);
        int hd, off;
        hd  = (m_tail - mq.size() + 16) % 16;
        off = (int'(pk) - hd + 16) % 16;
        return (off < mq.size()) ? off : -1;
    endfunction

    task automatic model_complete(logic [4:0] id);
        int off;
        off = held_off(id[4:1]);
        if (off >= 0) mq[off].done[id[0]] = 1'b1;
    endtask

    task automatic clear_pulses();
        flush = 0; alloc_vld = 0; alu0 = 0; alu1 = 0; mem = 0; excp_v = 0;
    endtask

    // Called just after a rising edge: records what the DUT must show this cycle,
    // advances the model by this cycle's inputs, then moves to the next cycle.
    task automatic tick();
        exp_t e;
        int   sz, hd, off;
        logic hvld;
        sz   = mq.size();
        hd   = (m_tail - sz + 16) % 16;
        hvld = (sz > 0) && (mq[0].done == 2'b11);
        e.vld   = hvld;
        e.pk    = 4'(hd);
        e.mask  = hvld ? exp_mask(mq[0]) : 2'b00;
        e.ex    = hvld && mq[0].ex;
        e.es    = hvld && mq[0].es;
        e.ec    = hvld ? mq[0].ec : 5'd0;
        e.full  = (sz == 16);
        e.empty = (sz == 0);
        e.occ   = 5'(sz);
        e.ap    = 4'(m_tail);
`ifdef ROB_PERF_CNT_EN
        e.pc = m_pc;
        e.ps = m_ps;
`else
        e.pc = 32'd0;
        e.ps = 32'd0;
`endif
        exp_q.push_back(e);

        if (sz > 0 && !hvld) m_ps++;
        if (flush) begin
            mq.delete();
            m_tail = 0;
        end else begin
            if (alu0) model_complete(alu0_id);
            if (alu1) model_complete(alu1_id);
            if (mem)  model_complete(mem_id);
            if (excp_v) begin
                off = held_off(excp_id[4:1]);
                if (off >= 0) begin
                    mq[off].done[excp_id[0]] = 1'b1;
                    if (!mq[off].ex || (excp_id[0] < mq[off].es)) begin
                        mq[off].ex = 1'b1;
                        mq[off].es = excp_id[0];
                        mq[off].ec = excp_cd;
                    end
                end
            end
            if (hvld && commit_rdy) begin
                m_pc += 32'(e.mask[0]) + 32'(e.mask[1]);
                void'(mq.pop_front());
            end
            if (alloc_vld && sz < 16) begin
                mq.push_back('{id: 4'(m_tail), am: alloc_slot, done: ~alloc_slot,
                               ex: 1'b0, es: 1'b0, ec: 5'd0});
                m_tail = (m_tail + 1) % 16;
            end
        end
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, " empty"}, empty, 1);
        chk({tag, " full"}, full, 0);
        chk({tag, " occupancy"}, occupancy, 0);
        chk({tag, " alloc_pack"}, alloc_pack, 0);
        chk({tag, " commit_vld"}, commit_vld, 0);
        chk({tag, " commit_pack"}, commit_pack, 0);
        chk({tag, " commit_mask"}, commit_mask, 0);
        chk({tag, " commit_excp"}, commit_excp, 0);
        chk({tag, " commit_excp_code"}, commit_excp_code, 0);
        chk({tag, " commit_excp_slot"}, commit_excp_slot, 0);
        chk({tag, " perf_commit"}, perf_commit, 0);
        chk({tag, " perf_stall"}, perf_stall, 0);
    endtask

    // Monitor: one expectation per cycle, compared at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("commit_vld", commit_vld, e.vld);
                if (e.vld) begin
                    chk("commit_pack", commit_pack, e.pk);
                    chk("commit_mask", commit_mask, e.mask);
                    chk("commit_excp", commit_excp, e.ex);
                    if (e.ex) begin
                        chk("commit_excp_slot", commit_excp_slot, e.es);
                        chk("commit_excp_code", commit_excp_code, e.ec);
                    end
                end
                chk("full", full, e.full);
                chk("empty", empty, e.empty);
                chk("occupancy", occupancy, e.occ);
                chk("alloc_pack", alloc_pack, e.ap);
                chk("perf_commit", perf_commit, e.pc);
                chk("perf_stall", perf_stall, e.ps);
            end
        end
    end

    function automatic logic [4:0] pick_id();
        int off;
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            off = $urandom_range(0, mq.size() - 1);
            return {mq[off].id, 1'($urandom)};
        end
        return 5'($urandom);
    endfunction

    initial begin
        int t;
        rst = 1; commit_rdy = 0; alloc_slot = 0;
        alu0_id = 0; alu1_id = 0; mem_id = 0; excp_id = 0; excp_cd = 0;
        clear_pulses();
        mq.delete(); m_tail = 0; m_pc = 0; m_ps = 0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 0;

        // Three commits (masks 11, 01, 10) with four stalled cycles in between.
        commit_rdy = 1;
        alloc_vld = 1; alloc_slot = 2'b11; tick();
        alloc_vld = 1; alloc_slot = 2'b01; alu0 = 1; alu0_id = 5'd0; tick();
        alloc_vld = 1; alloc_slot = 2'b10; alu1 = 1; alu1_id = 5'd1; tick();
        mem = 1; mem_id = 5'd2; tick();
        tick();
        tick();
        alu0 = 1; alu0_id = 5'd5; tick();
        tick();
`ifdef ROB_PERF_CNT_EN
        chk("plan perf_commit", perf_commit, 4);
        chk("plan perf_stall", perf_stall, 4);
`endif

        // Fill to 16, overflow attempt, then retire with allocation held.
        flush = 1; tick();
        commit_rdy = 0;
        for (int i = 0; i < 17; i++) begin
            alloc_vld = 1; alloc_slot = 2'b11; tick();
        end
        alloc_vld = 1; alu0 = 1; alu0_id = 5'd0; alu1 = 1; alu1_id = 5'd1; tick();
        commit_rdy = 1; alloc_vld = 1; tick();
        commit_rdy = 0; alloc_vld = 1; tick();
        tick();

        // Partial pack 2 (mask 01), then exception ordering on pack 3.
        flush = 1; tick();
        commit_rdy = 1;
        alloc_vld = 1; alloc_slot = 2'b00; tick();
        alloc_vld = 1; alloc_slot = 2'b00; tick();
        alloc_vld = 1; alloc_slot = 2'b01; tick();
        mem = 1; mem_id = 5'd4; tick();
        commit_rdy = 0;
        alloc_vld = 1; alloc_slot = 2'b11; tick();
        excp_v = 1; excp_id = 6'd7; excp_cd = 5'd5; tick();
        excp_v = 1; excp_id = 6'd6; excp_cd = 5'd2; tick();
        tick();
        commit_rdy = 1; tick();
        tick();

        // Flush beats same-cycle completion and allocation.
        commit_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            alloc_vld = 1; alloc_slot = 2'b11; tick();
        end
        flush = 1; alu0 = 1; alu0_id = {alloc_pack - 4'd1, 1'b0}; alloc_vld = 1; tick();
        tick();

        // Random traffic with a reset dropped in mid-stream.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #1 rst = 1;
                #1 check_reset_outputs("async reset");
                mq.delete(); m_tail = 0; m_pc = 0; m_ps = 0;
                @(posedge clk); #1;
                rst = 0;
            end
            t = (i / 150) % 4;
            alloc_vld  = ($urandom_range(0, 2) != 0);
            alloc_slot = 2'($urandom);
            commit_rdy = (t == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
            alu0 = ($urandom_range(0, 2) == 0); alu0_id = pick_id();
            alu1 = ($urandom_range(0, 2) == 0); alu1_id = pick_id();
            mem  = ($urandom_range(0, 3) == 0); mem_id = pick_id();
            excp_v = ($urandom_range(0, 9) == 0);
            excp_id = {1'($urandom), pick_id()};
            excp_cd = 5'($urandom);
            flush = ($urandom_range(0, 120) == 0);
            tick();
        end

        @(negedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
